serial_add_sub: RTL and testbench



---
 rtl/serial_add_sub_pkg.sv | 20 ++
 rtl/serial_add_sub_full_adder.sv | 16 +
 rtl/serial_add_sub.sv | 148 ++++++++++++++
 tb/tb_serial_add_sub.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding and
// a width helper for the bit counter.
package serial_add_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// One-bit full-adder slice, reused every cycle by the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain sum-of-products full adder.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor. One full-adder slice is walked
// over WIDTH cycles; operands are taken on a start/done handshake and result
// plus unsigned/signed flags are registered when the last bit completes.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] acc_shift;

  full_adder u_slice (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Sum bits enter from the MSB so the first (LSB) bit ends up at bit 0.
  assign acc_shift = {fa_sum, acc_q[WIDTH-1:1]};

  // Next-state: accept in IDLE/DONE, shift one bit per cycle in RUN.
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          opa_d   = a;
          // Subtraction is A + ~B + 1; the +1 rides in as the initial carry.
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end else begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StRun: begin
        acc_d   = acc_shift;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_cout;
        if (cnt_q == LastCnt) begin
          // carry_q is the carry into the MSB at this point.
          result_d = acc_shift;
          cout_d   = fa_cout;
          ovf_d    = carry_q ^ fa_cout;
          zero_d   = (acc_shift == '0);
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8): directed table, corner
// sequences, and random operations against an arithmetic reference model.
module tb_serial_add_sub;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  int n_vec;
  int n_err;

  serial_add_sub #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  // Reference: plain integer arithmetic; returns {result, carry, overflow, zero}.
  function automatic logic [W+2:0] model(logic s, logic [W-1:0] av, logic [W-1:0] bv);
    int unsigned u;
    int          sg;
    logic [W-1:0] r;
    logic c, v;
    if (s) begin
      u  = int'(av) + (256 - int'(bv));
      sg = int'($signed(av)) - int'($signed(bv));
    end else begin
      u  = int'(av) + int'(bv);
      sg = int'($signed(av)) + int'($signed(bv));
    end
    r = u[W-1:0];
    c = (u >= 256);
    v = (sg > 127) || (sg < -128);
    return {r, c, v, (r == '0)};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called on the negedge right after the accept edge (lat0 edges already seen).
  task automatic wait_done(input int lat0, output int lat, output int bc);
    lat = lat0;
    bc  = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat, output int bc);
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    // Operand changes during RUN must not matter.
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);
    wait_done(1, lat, bc);
  endtask

  function automatic logic [W+2:0] outs();
    return {result, carry_out, overflow, zero};
  endfunction

  vec_t vecs[8];

  initial begin
    int lat, bc, dcnt;
    logic [W+2:0] m;
    logic [W-1:0] ea, eb;
    logic         es;

    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;

    vecs[0] = '{1'b0, 8'h3C, 8'h0A, 8'h46, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outputs", 16'({busy, done, result, carry_out, overflow, zero}), 16'h0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].s, vecs[i].av, vecs[i].bv, lat, bc);
      check($sformatf("tbl%0d_latency", i), 16'(lat), 16'd9);
      check($sformatf("tbl%0d_busy_cycles", i), 16'(bc), 16'd8);
      check($sformatf("tbl%0d_outputs", i), 16'(outs()),
            16'({vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z}));
      // Result and flags hold through IDLE; done is a single pulse.
      @(negedge clk);
      @(negedge clk);
      check($sformatf("tbl%0d_hold", i), 16'({done, busy, outs()}),
            16'({2'b00, vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z}));
    end

    // start pulsed mid-RUN is ignored.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h3C; b = 8'h0A;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, lat, bc);
    check("midrun_latency", 16'(lat), 16'd9);
    check("midrun_result", 16'(result), 16'h46);
    // Accept in the DONE cycle.
    start = 1'b1; sub = 1'b0; a = 8'h11; b = 8'h22;
    @(negedge clk);
    check("done_accept_busy_done", 16'({busy, done}), 16'b10);
    start = 1'b0;
    wait_done(1, lat, bc);
    check("done_accept_latency", 16'(lat), 16'd9);
    check("done_accept_result", 16'(result), 16'h33);

    // Reset during the 4th RUN cycle aborts without done.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h3C; b = 8'h0A;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", 16'({busy, done, result, carry_out, overflow, zero}), 16'h0);
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    check("abort_no_done", 16'(dcnt), 16'd0);
    do_op(1'b1, 8'h10, 8'h10, lat, bc);
    check("after_abort_latency", 16'(lat), 16'd9);
    check("after_abort_outputs", 16'(outs()), 16'({8'h00, 1'b1, 1'b0, 1'b1}));

    // start held high: back-to-back ops every 9 cycles.
    @(negedge clk);
    ea = W'($urandom); eb = W'($urandom); es = 1'($urandom);
    start = 1'b1; a = ea; b = eb; sub = es;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) check($sformatf("b2b%0d_pulse", i), 16'({busy, done}), 16'b10);
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      wait_done(1, lat, bc);
      m = model(es, ea, eb);
      check($sformatf("b2b%0d_latency", i), 16'(lat), 16'd9);
      check($sformatf("b2b%0d_outputs", i), 16'(outs()), 16'(m));
      ea = W'($urandom); eb = W'($urandom); es = 1'($urandom);
      a = ea; b = eb; sub = es;
    end
    start = 1'b0;
    @(negedge clk);

    // Random single operations against the model.
    for (int i = 0; i < 30; i++) begin
      ea = W'($urandom); eb = W'($urandom); es = 1'($urandom);
      if (i < 4) eb = (i % 2 == 0) ? ea : 8'h80;
      do_op(es, ea, eb, lat, bc);
      m = model(es, ea, eb);
      check($sformatf("rnd%0d_latency", i), 16'(lat), 16'd9);
      check($sformatf("rnd%0d_outputs a=%h b=%h sub=%0d", i, ea, eb, es), 16'(outs()), 16'(m));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
